// File: rtl/stream_upsizer.sv
// stream_upsizer: packs a narrow valid/ready beat stream into wide words,
// little-endian by lane, with early word closure on in_last.
// Output side is fully registered; in_ready depends only on out_ready and
// the registered out_valid.

module stream_upsizer #(
    parameter int IN_WIDTH = 8,
    parameter int RATIO    = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [IN_WIDTH-1:0]       in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [IN_WIDTH*RATIO-1:0] out_data,
    output logic [RATIO-1:0]          out_keep,
    output logic                      out_last
);

    localparam int unsigned OUT_WIDTH = IN_WIDTH * RATIO;
    localparam int unsigned CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

    // Reject degenerate geometries at elaboration time.
    if (RATIO < 1 || IN_WIDTH < 1) begin : g_param_check
        $fatal(1, "stream_upsizer: RATIO and IN_WIDTH must both be >= 1");
    end

    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic [OUT_WIDTH-1:0] data_q,  data_d;
    logic [RATIO-1:0]     keep_q,  keep_d;
    logic                 last_q,  last_d;
    logic                 valid_q, valid_d;
    logic                 accept;

    // Input may be taken whenever the output register is empty or draining.
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

    // Next-state: lane write, word completion and output retirement.
    always_comb begin
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        valid_d = valid_q;

        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (accept) begin
            // First beat of a word wipes stale lanes of the previous word.
            if (cnt_q == '0) begin
                data_d = '0;
                keep_d = '0;
                last_d = 1'b0;
            end

            for (int k = 0; k < RATIO; k++) begin
                if (cnt_q == CNT_W'(k)) begin
                    data_d[k*IN_WIDTH +: IN_WIDTH] = in_data;
                    keep_d[k]                      = 1'b1;
                end
            end

            if (cnt_q == LAST_LANE || in_last) begin
                valid_d = 1'b1;
                last_d  = in_last;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset discards any partial word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Packs a narrow valid/ready byte stream into wide words for a downstream wide FIFO's write port.
- Accepts RATIO narrow beats per output word. Packing is little-endian: first beat goes in the lowest lane.
- A beat with in_last closes the word early and produces a partial word, marked by out_keep.
- Output side is fully registered, so it meets a FIFO write port (w_valid/w_ready/w_data) without combinational paths.

Parameters:
- IN_WIDTH, 8, bit width of one input beat (one lane).
- RATIO, 4, number of lanes per output word. Must be >= 1; elaboration fails with $fatal otherwise. IN_WIDTH must also be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  input beat valid.
- in_ready  output  1  input beat accepted when in_valid && in_ready.
- in_data  input  IN_WIDTH  input beat payload.
- in_last  input  1  beat closes the current word (packet end).
- out_valid  output  1  packed word valid.
- out_ready  input  1  downstream accepts word.
- out_data  output  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- out_keep  output  RATIO  bit k set when lane k holds a written beat.
- out_last  output  1  word ends a packet (closed by in_last).

Behaviour:
- State: lane counter cnt (0..RATIO-1, width $clog2(RATIO), min 1), data/keep/last register, out_valid flag.
- Reset (asynchronous, any time, including mid-word): out_valid=0, out_data=0, out_keep=0, out_last=0, cnt=0. Any partial word is discarded.
- in_ready = !out_valid || out_ready. It is combinational from out_ready only and never depends on in_valid.
- out_valid, out_data, out_keep and out_last are register outputs, with no combinational path from any input.
- Accepted beat, with lane index cnt:
  - writes in_data to lane cnt;
  - sets keep[cnt];
  - if cnt == RATIO-1 or in_last: out_valid <= 1, out_last <= in_last, cnt <= 0;
  - otherwise cnt <= cnt+1 and out_valid stays 0.
- Accepted beat when cnt == 0 (start of a word): all other lanes are cleared to 0, keep is cleared to only bit 0, and out_last is cleared.
- Output handshake: out_valid && out_ready retires the word. out_valid <= 0 unless the same-cycle input beat completes a new word.
- Simultaneous retire and accept:
  - the beat is written into lane 0 of the new word (cnt is 0 after completion);
  - with RATIO=1, or with in_last, the new word is complete immediately and out_valid stays 1.
  - Sustained throughput is 1 input beat/cycle with no bubbles while out_ready=1.
- Stall: while out_valid && !out_ready, out_data, out_keep and out_last hold stable and in_ready=0.
- Latency: a word is presented in the cycle after the handshake of its completing beat.
- Partial words: unwritten lanes read 0 and their keep bits are 0. Keep is always contiguous from bit 0.
- in_last on the lane RATIO-1 beat: full word, out_keep all ones, out_last=1.
- RATIO=1: every beat forms a word. out_keep=1'b1. Behaves as a 1-entry register slice.
- Data is never dropped or duplicated. Input beat order maps to ascending lanes, then to output word order.

Test Plan:
- IN_WIDTH=8, RATIO=4, out_ready=1, beats 0x11,0x22,0x33,0x44 with no last -> one word, out_data=0x44332211, out_keep=4'b1111, out_last=0. out_valid rises 1 cycle after the 4th handshake.
- Beats 0xAA,0xBB with last on 0xBB -> out_data=0x0000BBAA, out_keep=4'b0011, out_last=1. The next word starts at lane 0 with keep cleared.
- Back-to-back: 12 beats 0x01..0x0C, in_valid=1 and out_ready=1 every cycle -> in_ready stays 1. Output is 0x04030201, 0x08070605, 0x0C0B0A09 on cycles 5, 9, 13.
- Back-pressure: word 0x44332211 complete and out_ready=0 for 5 cycles -> in_ready=0 and outputs stable. When out_ready=1 together with in_valid and beat 0x55, the word retires and 0x55 lands in lane 0.
- Reset mid-word: after 2 beats, assert rstn=0 asynchronously -> all outputs 0 immediately. After release, beats 0x01..0x04 give 0x04030201 with no stale lanes.
- RATIO=1, IN_WIDTH=8: beats 0x5A then 0xA5 with last, out_ready=1 -> words 0x5A/keep 1/last 0 then 0xA5/keep 1/last 1 on consecutive cycles.
